// File: rtl/seq_sorter.sv
// Batch sorter: loads DEPTH words, sorts them with odd-even transposition,
// then drains them in ascending (or descending) order.
module seq_sorter #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 8,
    parameter bit DESCEND = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] elem     [DEPTH];
    logic [WIDTH-1:0] elem_nxt [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOAD;
            cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                elem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                elem[i] <= elem_nxt[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        for (int i = 0; i < DEPTH; i++) begin
            elem_nxt[i] = elem[i];
        end
        unique case (state)
            LOAD: begin
                if (in_valid) begin
                    elem_nxt[cnt] = in_data;
                    if (cnt == LAST) begin
                        state_nxt = SORT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            SORT: begin
                // cnt[0] selects the phase: even pairs first, then odd pairs
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (((i % 2) == 1) == cnt[0]) begin
                        if (DESCEND ? (elem[i] < elem[i+1])
                                    : (elem[i] > elem[i+1])) begin
                            elem_nxt[i]   = elem[i+1];
                            elem_nxt[i+1] = elem[i];
                        end
                    end
                end
                if (cnt == LAST) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt == LAST) begin
                        state_nxt = LOAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state == SORT) || (state == DRAIN);
    assign out_data  = (state == DRAIN) ? elem[cnt] : '0;

endmodule

// File: doc/seq_sorter.md
SEQ_SORTER -- requirements
Module: seq_sorter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: bit width of each data word.
REQ-002 The block SHALL have parameter DEPTH, default 8: words per batch; legal values even and >= 2.
REQ-003 The block SHALL have parameter DESCEND, default 0: 0 gives ascending output order, 1 gives descending.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a word.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: unsigned input word.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a sorted word.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: sorted output word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-012 The block SHALL have port busy, output, 1 bit: the block is in SORT or DRAIN.

Function
REQ-013 The block SHALL hold DEPTH registers of WIDTH bits, elem[0..DEPTH-1], plus a counter of $clog2(DEPTH) bits (minimum 1) and a 3-state FSM: LOAD, SORT, DRAIN.
REQ-014 In LOAD, in_ready SHALL be 1, and each edge with in_valid=1 SHALL write in_data to elem[cnt] and increment cnt.
REQ-015 LOAD SHALL go to SORT, with cnt cleared to 0, on the edge that accepts word DEPTH-1; gaps in in_valid stall loading with no data loss.
REQ-016 Outside LOAD, in_ready SHALL be 0 and in_valid/in_data SHALL be ignored.
REQ-017 SORT SHALL perform one odd-even transposition pass per edge, for exactly DEPTH edges.
REQ-018 SORT passes SHALL alternate even phase (pairs 0-1, 2-3, ...) and odd phase (pairs 1-2, 3-4, ...; elem[0] and elem[DEPTH-1] unchanged), starting with even.
REQ-019 Each pair compare-swap SHALL be an unsigned compare, swapping only if lower-index > higher-index (DESCEND=0) or lower-index < higher-index (DESCEND=1); equal values are never swapped.
REQ-020 SORT SHALL go to DRAIN, with cnt=0, on the DEPTH-th SORT edge, so out_valid first rises exactly DEPTH edges after the edge that accepted the last input word.
REQ-021 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal elem[cnt].
REQ-022 In DRAIN, an edge with out_ready=1 SHALL increment cnt.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-024 On the edge accepting word DEPTH-1 in DRAIN, the FSM SHALL go to LOAD with cnt=0; in_ready SHALL be 1 in the next cycle (no back-to-back overlap of batches).
REQ-025 Outside DRAIN, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-026 busy SHALL be 1 iff the state is SORT or DRAIN.
REQ-027 in_ready, out_valid, out_data and busy SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-028 On an edge with RST=1, the block SHALL set state to LOAD, cnt to 0 and all elem to 0, regardless of state.
REQ-029 After such a reset, in_ready SHALL be 1, out_valid 0, out_data 0 and busy 0.
REQ-030 RST SHALL take priority over every load, sort and drain action on the same edge.
REQ-031 Reset mid-batch SHALL discard all partially loaded, sorted or undrained data; the next batch starts from index 0.

Verification (WIDTH=4, DEPTH=8 unless stated)
REQ-032 Reset: hold RST=1 for 2 edges -> in_ready=1, out_valid=0, out_data=0, busy=0.
REQ-033 Basic sort: load 5,3,7,0,15,1,1,9 back-to-back -> out_valid rises 8 edges after the last accept; with out_ready=1, drain 0,1,1,3,5,7,9,15; then in_ready=1.
REQ-034 Corner data: test sorted input 0..7, reverse input 7..0, all-equal 10 x8, and all-max 15 x8 -> outputs 0..7, 0..7, 10 x8, 15 x8.
REQ-035 Backpressure: drive in_valid with gaps and toggle out_ready 1,0,0,1,... during drain -> no word lost or duplicated, and out_data stable while out_ready=0.
REQ-036 Reset mid-SORT: assert RST on the 3rd SORT edge -> LOAD state next cycle; a fresh batch 2,1,... sorts correctly with no stale values.
REQ-037 DESCEND=1 with the basic data -> drain 15,9,7,5,3,1,1,0. DEPTH=2 with data 3,1 -> drain 1,3.
